// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: self-synchronising hunt, free-running
// reference once locked, saturating error/bit counters and windowed loss-of-lock.
module prbs31_checker #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_THRESH = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned HIST_W  = 31;
  localparam int unsigned FILL_W  = 5;
  localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int unsigned WIN_W   = 6;
  localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [HIST_W-1:0]   hist, hist_nxt;
  logic [FILL_W-1:0]   fill, fill_nxt;
  logic [MATCH_W-1:0]  match_cnt, match_nxt;
  logic [WIN_W-1:0]    win_cnt, win_nxt;
  logic [WERR_W-1:0]   win_err, werr_nxt;
  logic [CNT_W-1:0]    err_nxt, bit_nxt;
  logic                pulse_nxt;
  logic                pred, mismatch;

  assign pred     = hist[HIST_W-1] ^ hist[HIST_W-4];
  assign mismatch = din ^ pred;

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    match_nxt = match_cnt;
    win_nxt   = win_cnt;
    werr_nxt  = win_err;
    err_nxt   = err_cnt;
    bit_nxt   = bit_cnt;
    pulse_nxt = 1'b0;

    if (din_valid) begin
      unique case (state)
        ST_HUNT: begin
          hist_nxt = {hist[HIST_W-2:0], din};
          if (fill != FILL_W'(HIST_W)) begin
            fill_nxt = fill + 1'b1;
          end else if ((hist == '0) || mismatch) begin
            match_nxt = '0;
          end else begin
            match_nxt = match_cnt + 1'b1;
            if (match_nxt == MATCH_W'(LOCK_THRESH)) begin
              state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          // Reference free-runs so a received error is not fed back into it
          hist_nxt  = {hist[HIST_W-2:0], pred};
          pulse_nxt = mismatch;
          if (bit_cnt != '1) begin
            bit_nxt = bit_cnt + 1'b1;
          end
          if (mismatch && (err_cnt != '1)) begin
            err_nxt = err_cnt + 1'b1;
          end
          win_nxt = win_cnt + 1'b1;
          if (win_cnt == '1) begin
            werr_nxt = WERR_W'(mismatch);
          end else begin
            werr_nxt = win_err + WERR_W'(mismatch);
          end
          if (werr_nxt == WERR_W'(LOSS_THRESH)) begin
            state_nxt = ST_HUNT;
            fill_nxt  = '0;
            match_nxt = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end

    if (clr_cnt) begin
      err_nxt = '0;
      bit_nxt = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_nxt;
      win_err   <= werr_nxt;
      locked    <= (state_nxt == ST_LOCKED);
      err_pulse <= pulse_nxt;
      err_cnt   <= err_nxt;
      bit_cnt   <= bit_nxt;
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboarded bench for prbs31_checker: stimulus feeds a behavioural reference
// that queues the expected outputs; a monitor pops and compares every cycle.
module tb_prbs31_checker;

  localparam int unsigned CNT_W   = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, din_valid, din, clr_cnt;
  logic             locked, err_pulse;
  logic [CNT_W-1:0] err_cnt, bit_cnt;

  always #5 clk = ~clk;

  prbs31_checker #(.CNT_W(CNT_W), .LOCK_THRESH(64), .LOSS_THRESH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  typedef struct packed {
    logic             lk;
    logic             pl;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] bc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses  = 0;

  // Reference model: bits fed to the reference, oldest first (31 entries)
  bit m_recent[$];
  bit m_locked, m_pulse;
  int m_fill, m_match, m_win, m_werr, m_err, m_bit;

  logic [30:0] gen;

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit d, input bit c);
    bit pred, hz, mis, inb;
    if (r) begin
      m_locked = 0; m_pulse = 0;
      m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_err = 0; m_bit = 0;
      m_recent.delete();
      for (int i = 0; i < 31; i++) m_recent.push_back(1'b0);
    end else begin
      m_pulse = 0;
      if (v) begin
        // Bits 31 and 28 positions back predict the next one
        pred = m_recent[0] ^ m_recent[3];
        hz = 1;
        foreach (m_recent[i]) if (m_recent[i]) hz = 0;
        mis = (d != pred);
        if (!m_locked) begin
          inb = d;
          if (m_fill < 31) m_fill++;
          else if (hz || mis) m_match = 0;
          else begin
            m_match++;
            if (m_match == 64) m_locked = 1;
          end
        end else begin
          inb = pred;
          m_pulse = mis;
          m_bit = sat_inc(m_bit);
          if (mis) m_err = sat_inc(m_err);
          if (m_win == 63) m_werr = int'(mis);
          else m_werr = m_werr + int'(mis);
          m_win = (m_win + 1) % 64;
          if (m_werr == 8) begin
            m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
          end
        end
        void'(m_recent.pop_front());
        m_recent.push_back(inb);
      end
      if (c) begin
        m_err = 0;
        m_bit = 0;
      end
    end
    exp_q.push_back('{lk: m_locked, pl: m_pulse, ec: CNT_W'(m_err), bc: CNT_W'(m_bit)});
  endtask

  task automatic cyc(input bit r, input bit v, input bit d, input bit c);
    @(negedge clk);
    rst = r; din_valid = v; din = d; clr_cnt = c;
    model_step(r, v, d, c);
  endtask

  task automatic gen_bit(output bit b);
    b   = gen[30] ^ gen[27];
    gen = {gen[29:0], b};
  endtask

  task automatic send_bit(input bit flip, input bit c);
    bit b;
    gen_bit(b);
    cyc(1'b0, 1'b1, b ^ flip, c);
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every registered output update is compared against the queue
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if ({locked, err_pulse, err_cnt, bit_cnt} !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: locked=%b err_pulse=%b err_cnt=%0d bit_cnt=%0d, expected %b %b %0d %0d",
                 $time, locked, err_pulse, err_cnt, bit_cnt, mon_e.lk, mon_e.pl, mon_e.ec, mon_e.bc);
      end
      if (err_pulse === 1'b1) pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, nv, k;
    bit b;
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;

    // Reset with random input activity
    repeat (2) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    sample();
    check("reset_locked", locked, 0);
    check("reset_err_pulse", err_pulse, 0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_bit_cnt", bit_cnt, 0);

    // Clean acquisition
    gen = 31'h7FFF_FFFF;
    send_clean(94);
    sample();
    check("acq_no_lock_at_94", locked, 0);
    send_clean(1);
    sample();
    check("acq_lock_at_95", locked, 1);
    send_clean(1000);
    sample();
    check("acq_bit_cnt", bit_cnt, 1000);
    check("acq_err_cnt", err_cnt, 0);

    // Single error
    p0 = pulses;
    send_bit(1'b1, 1'b0);
    send_clean(5);
    sample();
    check("single_pulses", pulses - p0, 1);
    check("single_err_cnt", err_cnt, 1);
    check("single_locked", locked, 1);

    // Loss of lock: eight errors inside one window
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    while (m_win != 0) send_clean(1);
    p0 = pulses;
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1, 1'b0);
      send_clean(1);
    end
    sample();
    check("loss_locked_after_7", locked, 1);
    send_bit(1'b1, 1'b0);
    sample();
    check("loss_unlocked_on_8", locked, 0);
    check("loss_err_cnt", err_cnt, 8);
    check("loss_pulses", pulses - p0, 8);
    send_clean(94);
    sample();
    check("relock_not_at_94", locked, 0);
    send_clean(1);
    sample();
    check("relock_at_95", locked, 1);

    // Degenerate all-zero input, then a real stream
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("zeros_no_lock", locked, 0);
    check("zeros_err_cnt", err_cnt, 0);
    gen = 31'h7FFF_FFFF;
    send_clean(95);
    sample();
    check("zeros_then_prbs_locked", locked, 1);

    // Random valid gaps: lock point counted in valid bits
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    gen = 31'h7FFF_FFFF;
    nv  = 0;
    while (nv < 94) begin
      if ($urandom_range(0, 1) == 1) begin
        send_bit(1'b0, 1'b0);
        nv++;
      end else begin
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    repeat (3) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    sample();
    check("stall_no_lock_at_94", locked, 0);
    send_clean(1);
    sample();
    check("stall_lock_at_95", locked, 1);

    // Clear coincident with an error
    send_clean(10);
    send_bit(1'b1, 1'b1);
    sample();
    check("clr_err_cnt", err_cnt, 0);
    check("clr_locked", locked, 1);
    send_clean(5);
    sample();
    check("clr_bit_cnt_after", bit_cnt, 5);

    // Reset while locked
    gen_bit(b);
    cyc(1'b1, 1'b1, b, 1'b0);
    sample();
    check("rst_locked", locked, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    send_clean(40);
    sample();
    check("rst_reacquire_pending", locked, 0);

    // Drain the scoreboard with a bounded wait
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Serial PRBS31 checker (x^31 + x^28 + 1) that sits directly downstream of the PRBS31 generator in the TinyTapeout test design and consumes its bit stream. It self-synchronises to the incoming sequence, declares lock after a run of correct predictions, then free-runs its own reference LFSR. It counts bit errors against that reference and drops lock when the error density is too high. Counters are readable by the top-level wrapper through the output pins.

## Interface
- `CNT_W`, default 16: width of `err_cnt` and `bit_cnt`; both counters saturate.
- `LOCK_THRESH`, default 64: consecutive correct predictions in HUNT required to enter LOCKED.
- `LOSS_THRESH`, default 8: errors within one 64-bit window in LOCKED that force a return to HUNT.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `din_valid` input, 1 bit: `din` carries a stream bit this cycle.
- `din` input, 1 bit: received PRBS bit.
- `clr_cnt` input, 1 bit: synchronous clear of `err_cnt` and `bit_cnt`.
- `locked` output, 1 bit: state is LOCKED.
- `err_pulse` output, 1 bit: one-cycle pulse for each mismatching bit while LOCKED.
- `err_cnt` output, `CNT_W` bits: errors counted while LOCKED.
- `bit_cnt` output, `CNT_W` bits: valid bits checked while LOCKED.

## Operation
- **History register.** `hist[30:0]`, where `hist[0]` is the most recent bit.
  - Prediction: `pred = hist[30] ^ hist[27]`.
  - Update on each valid bit: `hist <= {hist[29:0], in_bit}`.
- **HUNT state** (entered on reset):
  - `in_bit = din`.
  - `fill` counts valid bits up to 31 and saturates there.
  - A compare is made only when `fill == 31` and `hist != 0`.
  - On a match, `match_cnt` increments. On a mismatch, or when `hist == 0`, `match_cnt` is cleared.
  - When `match_cnt` reaches `LOCK_THRESH`, transition to LOCKED.
- **LOCKED state:**
  - `in_bit = pred`. The reference free-runs, so each received error is counted once, not tripled.
  - Each valid bit:
    - `bit_cnt` increments.
    - If `din != pred`: `err_pulse` asserts and `err_cnt` increments.
    - `win_cnt` (6 bits) advances.
    - `win_err` counts errors in the current window.
  - When `win_cnt` wraps from 63 to 0, `win_err` clears. An error landing on the wrap bit counts toward the new window.
  - When `win_err` reaches `LOSS_THRESH`, transition to HUNT. In the same cycle, clear `fill`, `match_cnt`, `win_cnt` and `win_err`; `hist` is retained. Re-lock therefore needs 31 fill bits plus `LOCK_THRESH` matches.
- **Cycles with `din_valid = 0`:** no state, counter or history change; `err_pulse = 0`.
- **Counter saturation:** both counters saturate at all-ones and never wrap.
- **`clr_cnt`:** has priority over an increment in the same cycle; the result is 0 and the coincident error or bit is dropped. It does not affect lock state or window logic.
- **Reset values:**
  - HUNT, `hist = 0`, all internal counters 0.
  - `locked = 0`, `err_pulse = 0`, `err_cnt = 0`, `bit_cnt = 0`.
- **`rst` during LOCKED:** takes effect at the next edge; the block must fully re-acquire.

## Timing
- All outputs are registered.
- `err_pulse` is high in the cycle after the edge that samples the erroneous valid bit; `err_cnt` updates on that same edge.
- `locked` rises on the edge that samples the `LOCK_THRESH`-th consecutive match.
  - Clean stream from reset, `din_valid` held high: that is valid bit 31 + 64 = 95, so `locked = 1` from the cycle after bit 95.
- `locked` falls on the edge that samples the `LOSS_THRESH`-th windowed error. That error is still counted and still pulses.
- The transition bit into LOCKED is not itself checked; `bit_cnt` starts on the next valid bit.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random `din` -> `locked = 0`, `err_pulse = 0`, `err_cnt = 0`, `bit_cnt = 0`.
- **Clean acquisition:** generator seeded `0x7FFFFFFF`, `din_valid = 1` -> `locked` rises after valid bit 95. After 1000 further bits: `bit_cnt = 1000`, `err_cnt = 0`.
- **Single error:** while LOCKED, invert one bit -> exactly one `err_pulse`, `err_cnt = 1`, `locked` stays 1.
- **Loss of lock:**
  - Invert 8 bits within one 64-bit window -> `locked` falls on the 8th error, `err_cnt = 8`.
  - Continue with a clean stream -> re-lock 95 valid bits later.
- **Degenerate input:** all-zero input for 500 bits -> never locks, `err_cnt = 0`. Then switch to a valid PRBS stream -> locks after 95 bits.
- **Stalls, clear and reset:**
  - Random `din_valid` gaps (50% duty) -> same lock point counted in valid bits.
  - `clr_cnt` in the same cycle as an error -> `err_cnt = 0`.
  - `rst` mid-LOCKED -> `locked = 0` next cycle.
